// File: rtl/multicycle_control.sv
// Multi-cycle control unit: latches the opcode and sequences FETCH/DECODE/EXEC/MEM/WB.
// Define PERF_CNT_EN to build the retired-instruction counter behind InstrCount.
module multicycle_control #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3,
    parameter int CNTW   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [OPW-1:0]    Instr,
    input  logic              Zero,
    input  logic              MemAck,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              ALUSrc,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              Busy,
    output logic              Done,
    output logic [CNTW-1:0]   InstrCount
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_STORE = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4);
    localparam logic [OPW-1:0] OP_OR    = OPW'(5);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6);
    localparam logic [OPW-1:0] OP_BEQZ  = OPW'(7);
    localparam logic [OPW-1:0] OP_HALT  = '1;

    localparam logic [ALUOPW-1:0] ALU_ADD  = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] ALU_SUB  = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] ALU_AND  = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] ALU_OR   = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] ALU_PASS = '1;

    state_t         r_state;
    state_t         w_next_state;
    logic [OPW-1:0] r_op;

    logic w_is_store;
    logic w_is_load;
    logic w_is_alu;
    logic w_is_addi;
    logic w_is_beqz;
    logic w_is_halt;
    logic w_is_mem;

    // Opcode classification of the latched instruction; anything unlisted behaves as NOP.
    always_comb begin
        w_is_store = (r_op == OP_STORE);
        w_is_load  = (r_op == OP_LOAD);
        w_is_addi  = (r_op == OP_ADDI);
        w_is_alu   = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_AND) ||
                     (r_op == OP_OR)  || w_is_addi;
        w_is_beqz  = (r_op == OP_BEQZ);
        w_is_halt  = (r_op == OP_HALT);
        w_is_mem   = w_is_store || w_is_load;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_op <= '0;
        end else if (r_state == ST_FETCH) begin
            r_op <= Instr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (Start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = w_is_halt ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                if (w_is_alu) begin
                    w_next_state = ST_WB;
                end else if (w_is_mem) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM: begin
                // No timeout: the data memory may stretch the access indefinitely.
                if (MemAck) w_next_state = w_is_load ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                w_next_state = ST_FETCH;
            end
            ST_HALTED: begin
                if (Start) w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_PASS;
        Busy     = 1'b0;
        Done     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
            end
            ST_FETCH: begin
                Busy    = 1'b1;
                IRWrite = 1'b1;
            end
            ST_DECODE: begin
                Busy = 1'b1;
            end
            ST_EXEC: begin
                Busy = 1'b1;
                if (w_is_mem) begin
                    ALUOp  = ALU_ADD;
                    ALUSrc = 1'b1;
                end else if (w_is_alu) begin
                    ALUSrc = w_is_addi;
                    if (r_op == OP_SUB) begin
                        ALUOp = ALU_SUB;
                    end else if (r_op == OP_AND) begin
                        ALUOp = ALU_AND;
                    end else if (r_op == OP_OR) begin
                        ALUOp = ALU_OR;
                    end else begin
                        ALUOp = ALU_ADD;
                    end
                end else begin
                    // BEQZ and NOP retire here; only a taken BEQZ selects the branch target.
                    PCWrite = 1'b1;
                    PCSrc   = w_is_beqz & Zero;
                end
            end
            ST_MEM: begin
                Busy     = 1'b1;
                MemRead  = w_is_load;
                MemWrite = w_is_store;
                PCWrite  = w_is_store & MemAck;
            end
            ST_WB: begin
                Busy     = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = w_is_load;
                PCWrite  = 1'b1;
            end
            ST_HALTED: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNTW-1:0] r_instr_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_instr_cnt <= '0;
        end else if (PCWrite) begin
            r_instr_cnt <= r_instr_cnt + CNTW'(1);
        end
    end

    assign InstrCount = r_instr_cnt;
`else
    assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes expected retire/halt events,
// a negedge monitor pops and compares them when PCWrite or a rising Done appears.
module tb_multicycle_control;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [3:0] Instr;
    logic       Zero;
    logic       MemAck;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       ALUSrc;
    logic [2:0] ALUOp;
    logic       Busy;
    logic       Done;
    logic [3:0] InstrCount;

    multicycle_control #(.OPW(4), .ALUOPW(3), .CNTW(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .Zero(Zero),
        .MemAck(MemAck), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Busy(Busy),
        .Done(Done), .InstrCount(InstrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic halt;
        logic pcsrc;
        logic regw;
        logic m2r;
        logic memw;
        int   lat;
    } exp_t;

    exp_t sbq[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   mcyc   = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Monitor: counts cycles since FETCH and checks each retire/halt against the queue.
    always @(negedge Clk) begin
        if (!Reset) begin
            prev_done = 1'b0;
        end else begin
            exp_t e;
            if (IRWrite) mcyc = 1;
            else mcyc++;
            chk("rd_wr_exclusive", 32'(MemRead & MemWrite), 0);
            chk("rw_mw_exclusive", 32'(RegWrite & MemWrite), 0);
            if (PCWrite) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("retire_not_halt", 32'(e.halt), 0);
                    chk("retire_pcsrc", 32'(PCSrc), 32'(e.pcsrc));
                    chk("retire_regwrite", 32'(RegWrite), 32'(e.regw));
                    chk("retire_memtoreg", 32'(MemtoReg), 32'(e.m2r));
                    chk("retire_memwrite", 32'(MemWrite), 32'(e.memw));
                    chk("retire_latency", 32'(mcyc), 32'(e.lat));
                end
            end
            if (Done && !prev_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_is_halt", 32'(e.halt), 1);
                    chk("done_latency", 32'(mcyc), 32'(e.lat));
                    chk("done_no_pcwrite", 32'(PCWrite), 0);
                end
            end
            prev_done = Done;
        end
    end

    // Runs one instruction starting in its FETCH cycle; leaves the DUT in the next FETCH
    // (or in HALTED for a HALT).
    task automatic run_instr(input logic [3:0] op, input logic z, input int nwait,
                             input logic e_pcsrc, input logic e_m2r, input logic e_memw,
                             input int e_regw, input int e_lat,
                             input logic [2:0] e_alu, input logic e_src,
                             input int e_rd, input int e_wr, input logic e_halt,
                             input string nm);
        exp_t e;
        int   cyc, rd, wr, rw, w;
        bit   fin;
        e.halt = e_halt; e.pcsrc = e_pcsrc; e.regw = (e_regw > 0);
        e.m2r = e_m2r; e.memw = e_memw; e.lat = e_lat;
        sbq.push_back(e);
        chk({nm, "_fetch"}, 32'(IRWrite), 1);
        Instr  = op;
        Zero   = z;
        w      = nwait;
        MemAck = (nwait == 0);
        cyc = 1; rd = 0; wr = 0; rw = 0; fin = 0;
        while (!fin && cyc < 60) begin
            tick();
            cyc++;
            if (MemRead || MemWrite) begin
                if (w > 0) begin
                    MemAck = 1'b0;
                    w--;
                end else begin
                    MemAck = 1'b1;
                end
            end
            #1;
            if (cyc == 3) begin
                chk({nm, "_aluop"}, 32'(ALUOp), 32'(e_alu));
                chk({nm, "_alusrc"}, 32'(ALUSrc), 32'(e_src));
            end
            rd += int'(MemRead);
            wr += int'(MemWrite);
            rw += int'(RegWrite);
            if (PCWrite || Done) fin = 1;
        end
        if (!fin) chk({nm, "_timeout"}, 1, 0);
        chk({nm, "_memread_cycles"}, 32'(rd), 32'(e_rd));
        chk({nm, "_memwrite_cycles"}, 32'(wr), 32'(e_wr));
        chk({nm, "_regwrite_cycles"}, 32'(rw), 32'(e_regw));
        if (!e_halt) tick();
        MemAck = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; Instr = 4'h0; Zero = 1'b0; MemAck = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_irwrite", 32'(IRWrite), 0);
        chk("rst_pcwrite", 32'(PCWrite), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_aluop", 32'(ALUOp), 32'h7);
        Reset = 1'b1;
        tick();
        chk("idle_busy", 32'(Busy), 0);
        chk("idle_irwrite", 32'(IRWrite), 0);

        Start = 1'b1;
        Instr = 4'b0001;
        tick();
        Start = 1'b0;
        //        op       z  nw pcs m2r mw  rw lat alu     src rd wr halt
        run_instr(4'b0001, 0, 0, 0,  0,  0,  1, 4, 3'b000, 0,  0, 0, 0, "add");
        run_instr(4'b0010, 0, 3, 0,  1,  0,  1, 8, 3'b000, 1,  4, 0, 0, "load_w3");
        run_instr(4'b0111, 1, 0, 1,  0,  0,  0, 3, 3'b111, 0,  0, 0, 0, "beqz_taken");
        run_instr(4'b0111, 0, 0, 0,  0,  0,  0, 3, 3'b111, 0,  0, 0, 0, "beqz_not_taken");
        run_instr(4'b0011, 0, 0, 0,  0,  0,  1, 4, 3'b001, 0,  0, 0, 0, "sub");
        run_instr(4'b0100, 0, 0, 0,  0,  0,  1, 4, 3'b010, 0,  0, 0, 0, "and");
        run_instr(4'b0101, 0, 0, 0,  0,  0,  1, 4, 3'b011, 0,  0, 0, 0, "or");
        run_instr(4'b0110, 0, 0, 0,  0,  0,  1, 4, 3'b000, 1,  0, 0, 0, "addi");
        run_instr(4'b0000, 0, 2, 0,  0,  1,  0, 6, 3'b000, 1,  0, 3, 0, "store_w2");
        run_instr(4'b0010, 0, 0, 0,  1,  0,  1, 5, 3'b000, 1,  1, 0, 0, "load_w0");
        run_instr(4'b1000, 0, 0, 0,  0,  0,  0, 3, 3'b111, 0,  0, 0, 0, "nop8");
        run_instr(4'b1010, 1, 0, 0,  0,  0,  0, 3, 3'b111, 0,  0, 0, 0, "nopa_zero");
        run_instr(4'b1111, 0, 0, 0,  0,  0,  0, 3, 3'b111, 0,  0, 0, 1, "halt");

        chk("halted_busy", 32'(Busy), 0);
        tick();
        chk("halted_stays", 32'(Done), 1);
        Start = 1'b1;
        tick();
        chk("resume_done", 32'(Done), 0);
        chk("resume_irwrite", 32'(IRWrite), 1);
        run_instr(4'b0001, 0, 0, 0,  0,  0,  1, 4, 3'b000, 0,  0, 0, 0, "add_start_held");
        Start = 1'b0;

        // Asynchronous reset in the middle of a stalled STORE.
        Instr  = 4'b0000;
        MemAck = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_mem_memwrite", 32'(MemWrite), 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_memwrite", 32'(MemWrite), 0);
        chk("async_rst_busy", 32'(Busy), 0);
        chk("async_rst_aluop", 32'(ALUOp), 32'h7);
        tick();
        tick();
        Reset  = 1'b1;
        MemAck = 1'b1;
        tick();
        chk("post_rst_busy", 32'(Busy), 0);
        chk("post_rst_irwrite", 32'(IRWrite), 0);
        chk("post_rst_done", 32'(Done), 0);
        chk("post_rst_aluop", 32'(ALUOp), 32'h7);
        chk("post_rst_count", 32'(InstrCount), 0);

        Start = 1'b1;
        Instr = 4'b1000;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            run_instr(4'b1000, 0, 0, 0, 0, 0, 0, 3, 3'b111, 0, 0, 0, 0, "nop_cnt");
        end
`ifdef PERF_CNT_EN
        chk("instr_count_wrap", 32'(InstrCount), 1);
`else
        chk("instr_count_tied", 32'(InstrCount), 0);
`endif
        chk("scoreboard_empty", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control unit; successor to the single-cycle combinational control decoder.
- Latches the opcode, then sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Drives the datapath strobes and ALUOp, and stalls on a data-memory handshake.
- Sits between the instruction ROM output and the datapath (PC, reg_file, ALU, data_mem).

Parameters:
- OPW, 4, opcode width. Opcodes are compared at full width, zero-extended.
- ALUOPW, 3, ALUOp width.
- CNTW, 16, width of the retired-instruction counter (optional feature only).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  level; begins or resumes execution from IDLE or HALTED.
- Instr  input  OPW  opcode from the instruction ROM, valid in FETCH.
- Zero  input  1  ALU zero flag, sampled in EXEC.
- MemAck  input  1  data memory completion, sampled in MEM.
- IRWrite  output  1  latch instruction register.
- PCWrite  output  1  update PC (one pulse per retired instruction).
- PCSrc  output  1  1: branch target, 0: PC+1.
- RegWrite  output  1  reg_file write enable.
- MemRead  output  1  data memory read request.
- MemWrite  output  1  data memory write request.
- MemtoReg  output  1  1: route memory to reg_file, 0: route ALU.
- ALUSrc  output  1  1: immediate, 0: second reg_file output.
- ALUOp  output  ALUOPW  ALU operation.
- Busy  output  1  high in FETCH through WB.
- Done  output  1  high in HALTED.
- InstrCount  output  CNTW  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED. The state register and opcode register (op) are the only sequential logic besides the optional counter.
- Outputs are a Moore decode of (state, op). Every output not listed for a state is 0. ALUOp defaults to 3'b111 (pass a).
- Reset low, at any time including mid-MEM: state = IDLE, op = 0, all outputs 0 immediately, ALUOp = 3'b111.
- Opcode map:
  - 0000 STORE
  - 0001 ADD (ALUOp 000)
  - 0010 LOAD
  - 0011 SUB (001)
  - 0100 AND (010)
  - 0101 OR (011)
  - 0110 ADDI (000, ALUSrc = 1)
  - 0111 BEQZ
  - all ones (OPW bits) HALT
  - anything else NOP
- IDLE: Start = 1 -> FETCH; otherwise stay.
- FETCH: IRWrite = 1; op <= Instr; -> DECODE.
- DECODE: -> EXEC. HALT -> HALTED directly, with no PCWrite.
- EXEC: ALUOp/ALUSrc per op; LOAD/STORE use ALUOp 000 with ALUSrc = 1 for address generation.
  - ALU ops -> WB.
  - LOAD/STORE -> MEM.
  - BEQZ: PCWrite = 1, PCSrc = Zero; -> FETCH.
  - NOP: PCWrite = 1, PCSrc = 0; -> FETCH.
- MEM: MemRead (LOAD) or MemWrite (STORE) is held high until the cycle MemAck = 1. MemAck = 0 stays in MEM with no timeout.
  - LOAD on ack -> WB.
  - STORE on ack: PCWrite = 1 in the same cycle; -> FETCH.
- WB: RegWrite = 1; MemtoReg = 1 for LOAD; PCWrite = 1; -> FETCH.
- HALTED: Done = 1; Start = 1 -> FETCH (resume at the next PC). Start held high in HALTED with no new HALT continues execution.
- Latency (Start to retire, MemAck tied high):
  - NOP/BEQZ: 3 cycles (F, D, E).
  - ALU: 4 cycles (F, D, E, W).
  - STORE: 4 cycles (F, D, E, M).
  - LOAD: 5 cycles (F, D, E, M, W).
  - Each cycle of MemAck = 0 adds one cycle.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1. PCWrite is exactly one pulse per non-HALT instruction.
- Start is ignored while Busy.
- MemAck outside MEM is ignored.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined: InstrCount is a CNTW-bit counter. It increments on every PCWrite pulse, wraps from all ones to 0, and is cleared by Reset.
- Not defined: no counter is built and InstrCount is tied to 0. The port list is unchanged.

Test Plan:
- Reset low mid-MEM of a STORE with MemAck = 0 -> MemWrite drops to 0 without a clock edge. After release: state IDLE, all outputs 0, ALUOp = 111.
- Start = 1, Instr = 0001 (ADD), MemAck = 1 -> IRWrite in cycle 1. ALUOp = 000 in cycle 3. RegWrite = 1 and PCWrite = 1 in cycle 4 only.
- LOAD (0010) with MemAck low for 3 MEM cycles then high -> MemRead high for 4 cycles. WB then shows RegWrite = 1, MemtoReg = 1. Total 8 cycles.
- BEQZ (0111) with Zero = 1, then with Zero = 0 -> PCWrite = 1 in EXEC both times, PCSrc = 1 then 0. RegWrite is never asserted.
- HALT (1111) -> Done = 1 in the cycle after DECODE, no PCWrite. Start pulse -> FETCH next cycle, Done = 0.
- PERF_CNT_EN defined, CNTW = 4: retire 17 NOPs (1000) -> InstrCount = 1 after wrap. Macro undefined -> InstrCount stays 0.
